// File: rtl/dict_match_encoder_pipe.sv
// Two-stage pipelined dictionary match encoder: per-word popcount/lowest-bit in S1,
// first-match or best-match word selection registered in S2, valid/ready on both sides.
module dict_match_encoder_pipe #(
    parameter  int unsigned NUM_WORDS      = 16,
    parameter  int unsigned BYTES_PER_WORD = 4,
    localparam int unsigned WIDX_W         = $clog2(NUM_WORDS),
    localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD),
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1),
    localparam int unsigned VEC_W          = NUM_WORDS * BYTES_PER_WORD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [VEC_W-1:0]          vec,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      hit,
    output logic [WIDX_W-1:0]         word_idx,
    output logic [BIDX_W-1:0]         byte_idx,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [BYTES_PER_WORD-1:0] match_mask
);

    function automatic logic [CNT_W-1:0] grp_popcount(input logic [BYTES_PER_WORD-1:0] g);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            cnt = cnt + CNT_W'(g[i]);
        end
        return cnt;
    endfunction

    function automatic logic [BIDX_W-1:0] grp_lowest(input logic [BYTES_PER_WORD-1:0] g);
        logic [BIDX_W-1:0] idx;
        logic              found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (g[i] && !found) begin
                idx   = BIDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // S1 state
    logic                                 s1_valid_q, s1_valid_d;
    logic [VEC_W-1:0]                     s1_vec_q, s1_vec_d;
    logic                                 s1_mode_q, s1_mode_d;
    logic [NUM_WORDS-1:0]                 s1_gvalid_q, s1_gvalid_d;
    logic [NUM_WORDS-1:0][CNT_W-1:0]      s1_pcnt_q, s1_pcnt_d;
    logic [NUM_WORDS-1:0][BIDX_W-1:0]     s1_lsb_q, s1_lsb_d;

    // S2 (output) state
    logic                      out_valid_q, out_valid_d;
    logic                      hit_q, hit_d;
    logic [WIDX_W-1:0]         word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]         byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]          match_cnt_q, match_cnt_d;
    logic [BYTES_PER_WORD-1:0] match_mask_q, match_mask_d;

    logic                      s2_load;
    logic [NUM_WORDS-1:0]      in_gvalid;
    logic [NUM_WORDS-1:0][CNT_W-1:0]  in_pcnt;
    logic [NUM_WORDS-1:0][BIDX_W-1:0] in_lsb;
    logic [WIDX_W-1:0]         sel;
    logic [CNT_W-1:0]          best_cnt;
    logic                      first_found;
    logic [BYTES_PER_WORD-1:0] sel_mask;

    // S2 takes a new entry whenever its current content is empty or being consumed
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    // Per-group summaries of the incoming vector
    always_comb begin
        in_gvalid = '0;
        in_pcnt   = '0;
        in_lsb    = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            in_gvalid[j] = |vec[j*BYTES_PER_WORD +: BYTES_PER_WORD];
            in_pcnt[j]   = grp_popcount(vec[j*BYTES_PER_WORD +: BYTES_PER_WORD]);
            in_lsb[j]    = grp_lowest(vec[j*BYTES_PER_WORD +: BYTES_PER_WORD]);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_vec_d    = s1_vec_q;
        s1_mode_d   = s1_mode_q;
        s1_gvalid_d = s1_gvalid_q;
        s1_pcnt_d   = s1_pcnt_q;
        s1_lsb_d    = s1_lsb_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_vec_d    = vec;
                s1_mode_d   = mode;
                s1_gvalid_d = in_gvalid;
                s1_pcnt_d   = in_pcnt;
                s1_lsb_d    = in_lsb;
            end
        end
    end

    // Strict '>' scanning upward keeps ties on the lowest word; no hit falls back to word 0
    always_comb begin
        sel         = '0;
        best_cnt    = '0;
        first_found = 1'b0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            if (s1_mode_q) begin
                if (s1_pcnt_q[j] > best_cnt) begin
                    best_cnt = s1_pcnt_q[j];
                    sel      = WIDX_W'(j);
                end
            end else if (s1_gvalid_q[j] && !first_found) begin
                sel         = WIDX_W'(j);
                first_found = 1'b1;
            end
        end
    end

    assign sel_mask = s1_vec_q[sel*BYTES_PER_WORD +: BYTES_PER_WORD];

    always_comb begin
        out_valid_d  = out_valid_q;
        hit_d        = hit_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        match_cnt_d  = match_cnt_q;
        match_mask_d = match_mask_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                hit_d        = |s1_gvalid_q;
                word_idx_d   = sel;
                byte_idx_d   = s1_lsb_q[sel];
                match_cnt_d  = s1_pcnt_q[sel];
                match_mask_d = sel_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_vec_q     <= '0;
            s1_mode_q    <= 1'b0;
            s1_gvalid_q  <= '0;
            s1_pcnt_q    <= '0;
            s1_lsb_q     <= '0;
            out_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            match_cnt_q  <= '0;
            match_mask_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_vec_q     <= s1_vec_d;
            s1_mode_q    <= s1_mode_d;
            s1_gvalid_q  <= s1_gvalid_d;
            s1_pcnt_q    <= s1_pcnt_d;
            s1_lsb_q     <= s1_lsb_d;
            out_valid_q  <= out_valid_d;
            hit_q        <= hit_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            match_cnt_q  <= match_cnt_d;
            match_mask_q <= match_mask_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign hit        = hit_q;
    assign word_idx   = word_idx_q;
    assign byte_idx   = byte_idx_q;
    assign match_cnt  = match_cnt_q;
    assign match_mask = match_mask_q;

endmodule

// File: tb/tb_dict_match_encoder_pipe.sv
// Directed bench for dict_match_encoder_pipe (16 words x 4 bytes); result fields are
// packed as {out_valid, hit, word_idx, byte_idx, match_cnt, match_mask}.
module tb_dict_match_encoder_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] vec;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic        hit;
    logic [3:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [2:0]  match_cnt;
    logic [3:0]  match_mask;
    logic [14:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    dict_match_encoder_pipe #(.NUM_WORDS(16), .BYTES_PER_WORD(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .vec(vec), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .word_idx(word_idx), .byte_idx(byte_idx),
        .match_cnt(match_cnt), .match_mask(match_mask)
    );

    assign obs = {out_valid, hit, word_idx, byte_idx, match_cnt, match_mask};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (obs !== 15'd0) begin
            $display("FAIL reset_outputs: got %h expected %h", obs, 15'd0);
            n_fail++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
            n_fail++;
        end
    endtask

    task automatic test_first_match();
        logic [63:0] v [4];
        logic [14:0] e [4];
        v = '{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0C00,
              64'h0000_0000_6000_0001, 64'hF000_0000_0000_0000};
        e = '{{1'b1, 1'b1, 4'd2,  2'd0, 3'd1, 4'b0001},
              {1'b1, 1'b1, 4'd2,  2'd2, 3'd2, 4'b1100},
              {1'b1, 1'b1, 4'd0,  2'd0, 3'd1, 4'b0001},
              {1'b1, 1'b1, 4'd15, 2'd0, 3'd4, 4'b1111}};
        for (int i = 0; i < 4; i++) begin
            vec = v[i]; mode = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; vec = '0;
            n_tests++;
            if (out_valid !== 1'b0) begin
                $display("FAIL first_latency[%0d]: got out_valid=%b expected 0", i, out_valid);
                n_fail++;
            end
            tick();
            n_tests++;
            if (obs !== e[i]) begin
                $display("FAIL first_result[%0d]: got %h expected %h", i, obs, e[i]);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_best_match();
        logic [63:0] v [4];
        logic [14:0] e [4];
        v = '{64'h0000_0000_0000_3030, 64'h0000_0000_6000_0001,
              64'h8000_0000_0000_0000, 64'h0000_0700_0000_0003};
        e = '{{1'b1, 1'b1, 4'd1,  2'd0, 3'd2, 4'b0011},
              {1'b1, 1'b1, 4'd7,  2'd1, 3'd2, 4'b0110},
              {1'b1, 1'b1, 4'd15, 2'd3, 3'd1, 4'b1000},
              {1'b1, 1'b1, 4'd10, 2'd0, 3'd3, 4'b0111}};
        for (int i = 0; i < 4; i++) begin
            vec = v[i]; mode = 1'b1; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; vec = '0; mode = 1'b0;
            tick();
            n_tests++;
            if (obs !== e[i]) begin
                $display("FAIL best_result[%0d]: got %h expected %h", i, obs, e[i]);
                n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_a;
        logic [14:0] exp_b;
        exp_a = {1'b1, 1'b1, 4'd1, 2'd0, 3'd1, 4'b0001};
        exp_b = {1'b1, 1'b1, 4'd5, 2'd0, 3'd4, 4'b1111};
        vec = 64'h0000_0000_00F0_0010; mode = 1'b0; in_valid = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        in_valid = 1'b0; mode = 1'b0; vec = '0;
        n_tests++;
        if (obs !== exp_a) begin
            $display("FAIL b2b_mode0: got %h expected %h", obs, exp_a);
            n_fail++;
        end
        tick();
        n_tests++;
        if (obs !== exp_b) begin
            $display("FAIL b2b_mode1: got %h expected %h", obs, exp_b);
            n_fail++;
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_no_dup: got out_valid=%b expected 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_no_hit();
        logic [14:0] exp_z;
        exp_z = {1'b1, 1'b0, 4'd0, 2'd0, 3'd0, 4'b0000};
        vec = '0; mode = 1'b0; in_valid = 1'b1;
        tick();
        mode = 1'b1;
        tick();
        in_valid = 1'b0; mode = 1'b0;
        n_tests++;
        if (obs !== exp_z) begin
            $display("FAIL nohit_mode0: got %h expected %h", obs, exp_z);
            n_fail++;
        end
        tick();
        n_tests++;
        if (obs !== exp_z) begin
            $display("FAIL nohit_mode1: got %h expected %h", obs, exp_z);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_stall();
        logic [14:0] exp_a;
        logic [14:0] exp_b;
        logic [14:0] exp_c;
        exp_a = {1'b1, 1'b1, 4'd0, 2'd0, 3'd1, 4'b0001};
        exp_b = {1'b1, 1'b1, 4'd2, 2'd0, 3'd1, 4'b0001};
        exp_c = {1'b1, 1'b1, 4'd4, 2'd0, 3'd1, 4'b0001};
        out_ready = 1'b0;
        vec = 64'h1; mode = 1'b0; in_valid = 1'b1;
        tick();
        vec = 64'h100;
        n_tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_ready_one: got %b expected 1", in_ready);
            n_fail++;
        end
        tick();
        vec = 64'h1_0000;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (in_ready !== 1'b0 || obs !== exp_a) begin
                $display("FAIL stall_hold[%0d]: got in_ready=%b out=%h expected 0/%h", i, in_ready, obs, exp_a);
                n_fail++;
            end
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
            n_fail++;
        end
        tick();
        in_valid = 1'b0; vec = '0;
        n_tests++;
        if (obs !== exp_b) begin
            $display("FAIL stall_out_b: got %h expected %h", obs, exp_b);
            n_fail++;
        end
        tick();
        n_tests++;
        if (obs !== exp_c) begin
            $display("FAIL stall_out_c: got %h expected %h", obs, exp_c);
            n_fail++;
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [14:0] exp_a;
        logic [14:0] exp_d;
        exp_a = {1'b1, 1'b1, 4'd0,  2'd0, 3'd1, 4'b0001};
        exp_d = {1'b1, 1'b1, 4'd12, 2'd1, 3'd1, 4'b0010};
        out_ready = 1'b0;
        vec = 64'h1; mode = 1'b0; in_valid = 1'b1;
        tick();
        vec = 64'h100;
        tick();
        in_valid = 1'b0; vec = '0;
        n_tests++;
        if (obs !== exp_a || in_ready !== 1'b0) begin
            $display("FAIL rst_full: got out=%h in_ready=%b expected %h/0", obs, in_ready, exp_a);
            n_fail++;
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (obs !== 15'd0 || in_ready !== 1'b1) begin
            $display("FAIL rst_async: got out=%h in_ready=%b expected 0000/1", obs, in_ready);
            n_fail++;
        end
        #3 reset = 1'b0;
        out_ready = 1'b1;
        vec = 64'h0002_0000_0000_0000; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; vec = '0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_discard: got out_valid=%b expected 0", out_valid);
            n_fail++;
        end
        tick();
        n_tests++;
        if (obs !== exp_d) begin
            $display("FAIL rst_first_after: got %h expected %h", obs, exp_d);
            n_fail++;
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_drain: got out_valid=%b expected 0", out_valid);
            n_fail++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        vec       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_first_match();
        test_best_match();
        test_back_to_back();
        test_no_hit();
        test_stall();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
